// File: rtl/apb_router_csr_if.sv
// APB bus bundle between the verification master and the router CSR completer.
// The completer side uses the slave modport; the driver uses master.
interface apb_router_csr_if;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pwrite;
  logic        psel;
  logic        penable;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata
  );
endinterface

// File: rtl/apb_router_csr.sv
// 4-port bit-serial router with its APB control/status registers.
// A two-bit MSB-first header selects the destination; payload follows with 1-cycle latency.
module apb_router_csr #(
  parameter int ADDR_LSB_W = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             presetn,
  apb_router_csr_if.slave  apb,
  input  logic             data_in,
  input  logic             valid_in,
  output logic             out_port1,
  output logic             out_port2,
  output logic             out_port3,
  output logic             out_port4,
  output logic             valid_out
);

  typedef enum logic [1:0] {IDLE, HDR1, FWD, DROP} state_t;

  localparam logic [ADDR_LSB_W-1:0] A_CTRL   = ADDR_LSB_W'(32'h00);
  localparam logic [ADDR_LSB_W-1:0] A_MASK   = ADDR_LSB_W'(32'h04);
  localparam logic [ADDR_LSB_W-1:0] A_STATUS = ADDR_LSB_W'(32'h08);
  localparam logic [ADDR_LSB_W-1:0] A_FWD0   = ADDR_LSB_W'(32'h10);
  localparam logic [ADDR_LSB_W-1:0] A_FWD1   = ADDR_LSB_W'(32'h14);
  localparam logic [ADDR_LSB_W-1:0] A_FWD2   = ADDR_LSB_W'(32'h18);
  localparam logic [ADDR_LSB_W-1:0] A_FWD3   = ADDR_LSB_W'(32'h1C);
  localparam logic [ADDR_LSB_W-1:0] A_DROP   = ADDR_LSB_W'(32'h20);
  localparam logic [CNT_W-1:0]      CNT_MAX  = {CNT_W{1'b1}};

  state_t                 state;
  logic [1:0]             dest;
  logic [3:0]             port_out;
  logic                   en;
  logic [3:0]             port_mask;
  logic [CNT_W-1:0]       fwd_cnt [4];
  logic [CNT_W-1:0]       drop_cnt;

  logic                   addr_ok;
  logic [ADDR_LSB_W-1:0]  addr_lo;
  logic                   wr_en;
  logic                   rd_setup;
  logic                   clr_cnt;
  logic [31:0]            rdata;
  logic [1:0]             hdr_dest;
  logic                   hdr_done;
  logic                   hdr_fwd;
  logic                   hdr_drop;
  logic                   unused_pwdata;

  // ---------------------------------------------------------------- APB decode
  assign addr_ok   = ~|apb.paddr[31:ADDR_LSB_W];
  assign addr_lo   = apb.paddr[ADDR_LSB_W-1:0];
  assign wr_en     = apb.psel & apb.penable & apb.pwrite & addr_ok;
  assign rd_setup  = apb.psel & ~apb.penable & ~apb.pwrite;
  // CLR_CNT is never stored: it acts on the commit edge, so it always beats an increment.
  assign clr_cnt   = wr_en && (addr_lo == A_CTRL) && apb.pwdata[1];
  assign unused_pwdata = ^apb.pwdata[31:4];

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      en        <= 1'b0;
      port_mask <= 4'hF;
    end else if (wr_en) begin
      if (addr_lo == A_CTRL) en        <= apb.pwdata[0];
      if (addr_lo == A_MASK) port_mask <= apb.pwdata[3:0];
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rdata = '0;
    if (addr_ok) begin
      case (addr_lo)
        A_CTRL:   rdata = {31'b0, en};
        A_MASK:   rdata = {28'b0, port_mask};
        A_STATUS: rdata = {29'b0, dest, (state != IDLE)};
        A_FWD0:   rdata = 32'(fwd_cnt[0]);
        A_FWD1:   rdata = 32'(fwd_cnt[1]);
        A_FWD2:   rdata = 32'(fwd_cnt[2]);
        A_FWD3:   rdata = 32'(fwd_cnt[3]);
        A_DROP:   rdata = 32'(drop_cnt);
        default:  rdata = '0;
      endcase
    end
  end

  // Loaded in SETUP, held through the single ACCESS cycle, then zero.
  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) apb.prdata <= '0;
    else          apb.prdata <= rd_setup ? rdata : '0;
  end

  // ---------------------------------------------------------------- router FSM
  assign hdr_dest = {dest[1], data_in};
  assign hdr_done = (state == HDR1) & valid_in;
  assign hdr_fwd  = hdr_done &  port_mask[hdr_dest];
  assign hdr_drop = hdr_done & ~port_mask[hdr_dest];

  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      state     <= IDLE;
      dest      <= '0;
      port_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in the same block.
      port_out  <= '0;
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (en) begin
              dest[1] <= data_in;
              state   <= HDR1;
            end else begin
              state   <= DROP;
            end
          end
        end
        HDR1: begin
          if (!valid_in) begin
            state <= IDLE;
          end else begin
            dest[0] <= data_in;
            state   <= port_mask[hdr_dest] ? FWD : DROP;
          end
        end
        FWD: begin
          if (valid_in) begin
            port_out[dest] <= data_in;
            valid_out      <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DROP: begin
          if (!valid_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_port1 = port_out[0];
  assign out_port2 = port_out[1];
  assign out_port3 = port_out[2];
  assign out_port4 = port_out[3];

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < 4; i++) fwd_cnt[i] <= '0;
      drop_cnt <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < 4; i++) fwd_cnt[i] <= '0;
      drop_cnt <= '0;
    end else begin
      if (hdr_fwd && fwd_cnt[hdr_dest] != CNT_MAX)
        fwd_cnt[hdr_dest] <= fwd_cnt[hdr_dest] + CNT_W'(1);
      if (hdr_drop && drop_cnt != CNT_MAX)
        drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_apb_router_csr.sv
// Directed bench for apb_router_csr: register defaults, routing, masking, counters, APB edges, reset.
// Counters are narrowed so saturation is reachable in a short run.
module tb_apb_router_csr;

  localparam int          CNT_W   = 10;
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic clk = 1'b0;
  logic presetn;
  logic data_in;
  logic valid_in;
  logic out_port1, out_port2, out_port3, out_port4;
  logic valid_out;
  logic [3:0] outs;
  logic [4:0] seen;
  logic [3:0] pay;

  int n_assert = 0;
  int n_fail   = 0;

  apb_router_csr_if apb ();

  apb_router_csr #(.ADDR_LSB_W(8), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .presetn   (presetn),
    .apb       (apb),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .out_port1 (out_port1),
    .out_port2 (out_port2),
    .out_port3 (out_port3),
    .out_port4 (out_port4),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  assign outs = {out_port4, out_port3, out_port2, out_port1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1;
    apb.paddr = addr; apb.pwdata = data;
    @(negedge clk);
    apb.penable = 1'b1;
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
  endtask

  task automatic apb_read_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b0; apb.paddr = addr;
    @(negedge clk);
    apb.penable = 1'b1;
    check(tag, apb.prdata, exp);
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0;
  endtask

  // nbits counts header bits too; seen ORs {valid_out, ports} over the frame and its drain.
  task automatic send_frame(input logic [1:0] dst, input int nbits, input logic [15:0] pl,
                            output logic [4:0] obs);
    obs = '0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      obs |= {valid_out, outs};
      valid_in = 1'b1;
      data_in  = (i == 0) ? dst[1] : (i == 1) ? dst[0] : pl[i-2];
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs |= {valid_out, outs};
      valid_in = 1'b0;
      data_in  = 1'b0;
    end
  endtask

  initial begin
    presetn = 1'b0; data_in = 1'b0; valid_in = 1'b0;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0; apb.pwdata = '0;

    // Reset defaults
    repeat (2) @(negedge clk);
    check("rst_outs", {27'b0, valid_out, outs}, 32'h0);
    check("rst_prdata", apb.prdata, 32'h0);
    presetn = 1'b1;
    apb_read_chk(32'h00, 32'h0, "rst_ctrl");
    apb_read_chk(32'h04, 32'hF, "rst_mask");
    apb_read_chk(32'h08, 32'h0, "rst_status");
    apb_read_chk(32'h10, 32'h0, "rst_fwd0");
    apb_read_chk(32'h14, 32'h0, "rst_fwd1");
    apb_read_chk(32'h18, 32'h0, "rst_fwd2");
    apb_read_chk(32'h1C, 32'h0, "rst_fwd3");
    apb_read_chk(32'h20, 32'h0, "rst_drop");
    check("post_rst_outs", {27'b0, valid_out, outs}, 32'h0);

    // Routing: header 2'b10, payload 1,0,1,1 appears on out_port3
    apb_write(32'h00, 32'h1);
    apb_read_chk(32'h00, 32'h1, "ctrl_en");
    pay = 4'b1101;
    @(negedge clk); valid_in = 1'b1; data_in = 1'b1;
    @(negedge clk); data_in = 1'b0;
    @(negedge clk);
    check("route_pre", {27'b0, valid_out, outs}, 32'h0);
    data_in = pay[0];
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("route_p%0d", i - 1), {27'b0, valid_out, outs},
            {27'b0, 1'b1, 1'b0, pay[i-1], 2'b00});
      if (i < 4) data_in = pay[i];
      else begin valid_in = 1'b0; data_in = 1'b0; end
    end
    @(negedge clk);
    check("route_end", {27'b0, valid_out, outs}, 32'h0);
    apb_read_chk(32'h18, 32'h1, "fwd2_one");
    apb_read_chk(32'h10, 32'h0, "fwd0_zero");
    apb_read_chk(32'h08, 32'h4, "status_dest2");

    // Mask port 2 off: dest 2 dropped, dest 3 still routed
    apb_write(32'h04, 32'hB);
    send_frame(2'd2, 5, 16'h0007, seen);
    check("mask_drop_out", {27'b0, seen}, 32'h0);
    apb_read_chk(32'h20, 32'h1, "drop_one");
    apb_read_chk(32'h18, 32'h1, "fwd2_kept");
    send_frame(2'd3, 4, 16'h0003, seen);
    check("mask_fwd3_out", {27'b0, seen}, 32'h18);
    apb_read_chk(32'h1C, 32'h1, "fwd3_one");

    // Disabled: frame swallowed, nothing counted
    apb_write(32'h00, 32'h0);
    send_frame(2'd1, 5, 16'h0007, seen);
    check("dis_out", {27'b0, seen}, 32'h0);
    apb_read_chk(32'h14, 32'h0, "dis_fwd1");
    apb_read_chk(32'h20, 32'h1, "dis_drop");

    // Runt frame
    apb_write(32'h00, 32'h1);
    send_frame(2'd2, 1, 16'h0000, seen);
    apb_read_chk(32'h20, 32'h1, "runt_drop");
    apb_read_chk(32'h18, 32'h1, "runt_fwd2");

    // APB boundaries
    apb_read_chk(32'h24, 32'h0, "unmapped_24");
    apb_read_chk(32'h100, 32'h0, "unmapped_100");
    apb_write(32'h24, 32'hFFFF_FFFF);
    apb_write(32'h104, 32'h0);
    apb_write(32'h100, 32'h0);
    apb_read_chk(32'h00, 32'h1, "unmapped_wr_ctrl");
    apb_read_chk(32'h04, 32'hB, "unmapped_wr_mask");

    @(negedge clk);
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 32'h04; apb.pwdata = 32'h5;
    @(negedge clk);
    apb.penable = 1'b1;
    @(negedge clk);
    apb.penable = 1'b0; apb.pwrite = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    check("b2b_mask", apb.prdata, 32'h5);
    @(negedge clk);
    apb.psel = 1'b0; apb.penable = 1'b0;
    check("prdata_after_access", apb.prdata, 32'h0);
    apb_write(32'h04, 32'hF);

    // Saturation of FWD_CNT0
    for (int i = 0; i < int'(CNT_MAX); i++) send_frame(2'd0, 2, 16'h0, seen);
    apb_read_chk(32'h10, CNT_MAX, "fwd0_full");
    send_frame(2'd0, 2, 16'h0, seen);
    apb_read_chk(32'h10, CNT_MAX, "fwd0_saturated");

    // CLR_CNT committed on the same edge that ends HDR1
    @(negedge clk);
    valid_in = 1'b1; data_in = 1'b0;
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 32'h00; apb.pwdata = 32'h3;
    @(negedge clk);
    data_in = 1'b0; apb.penable = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    repeat (2) @(negedge clk);
    apb_read_chk(32'h10, 32'h0, "clr_wins_fwd0");
    apb_read_chk(32'h18, 32'h0, "clr_fwd2");
    apb_read_chk(32'h20, 32'h0, "clr_drop");
    apb_read_chk(32'h00, 32'h1, "clr_reads_zero");

    // Async reset mid-frame
    apb_write(32'h04, 32'h7);
    @(negedge clk); valid_in = 1'b1; data_in = 1'b0;
    @(negedge clk); data_in = 1'b1;
    @(negedge clk); data_in = 1'b1;
    @(negedge clk); data_in = 1'b1;
    @(negedge clk);
    check("pre_rst_fwd", {27'b0, valid_out, outs}, 32'h12);
    #2 presetn = 1'b0; valid_in = 1'b0; data_in = 1'b0;
    #1 check("async_rst_outs", {27'b0, valid_out, outs}, 32'h0);
    @(negedge clk);
    presetn = 1'b1;
    apb_read_chk(32'h08, 32'h0, "rst2_status");
    apb_read_chk(32'h04, 32'hF, "rst2_mask");
    apb_read_chk(32'h00, 32'h0, "rst2_ctrl");
    apb_write(32'h00, 32'h1);
    send_frame(2'd1, 4, 16'h0001, seen);
    check("rst2_route", {27'b0, seen}, 32'h12);
    apb_read_chk(32'h14, 32'h1, "rst2_fwd1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
